// File: rtl/dcache_scrub_ctrl_if.sv
// Scrub-port bundle between the ECC scrub sequencer (master) and the
// cache-memory arbiter / SRAM read path (slave).
interface dcache_scrub_ctrl_if #(
   parameter int NUM_WAYS    = 8,
   parameter int INDEX_WIDTH = 8,
   parameter int LINE_WIDTH  = 144
);
   logic                           req;
   logic                           gnt;
   logic                           we;
   logic [NUM_WAYS-1:0]            way;
   logic [INDEX_WIDTH-1:0]         index;
   logic [LINE_WIDTH-1:0]          wdata;
   logic                           rvalid;
   logic [NUM_WAYS*LINE_WIDTH-1:0] rdata;
   logic [NUM_WAYS-1:0]            corr_err;
   logic [NUM_WAYS-1:0]            uncorr_err;

   modport master (
      output req, we, way, index, wdata,
      input  gnt, rvalid, rdata, corr_err, uncorr_err
   );

   modport slave (
      input  req, we, way, index, wdata,
      output gnt, rvalid, rdata, corr_err, uncorr_err
   );
endinterface

// File: rtl/dcache_scrub_ctrl.sv
// Background ECC scrub sequencer: walks all cache indices, rewrites corrected ways.
// Optional error log (first uncorrectable index/way) enabled by defining SCRUB_ERR_LOG_EN.
module dcache_scrub_ctrl #(
   parameter int NUM_WAYS       = 8,
   parameter int INDEX_WIDTH    = 8,
   parameter int LINE_WIDTH     = 144,
   parameter int INTERVAL_WIDTH = 16,
   parameter int STARVE_LIMIT   = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      enable_i,
   input  logic [INTERVAL_WIDTH-1:0] interval_i,
   dcache_scrub_ctrl_if.master       bus,
   output logic                      urgent_o,
   output logic                      busy_o,
   output logic [CNT_WIDTH-1:0]      corr_cnt_o,
   output logic [CNT_WIDTH-1:0]      uncorr_cnt_o
`ifdef SCRUB_ERR_LOG_EN
   ,
   input  logic                      err_clear_i,
   output logic                      err_valid_o,
   output logic [INDEX_WIDTH-1:0]    err_index_o,
   output logic [NUM_WAYS-1:0]       err_way_o
`endif
);

   localparam int POP_W    = $clog2(NUM_WAYS + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, WAIT, READ, CHECK, WRITE} state_e;

   state_e                         state_q, state_d;
   logic [INTERVAL_WIDTH-1:0]      wait_cnt_q;
   logic [INDEX_WIDTH-1:0]         index_q;
   logic [NUM_WAYS-1:0]            pend_q;
   logic [NUM_WAYS-1:0]            pend_low;
   logic [NUM_WAYS-1:0]            fix_mask;
   logic [NUM_WAYS*LINE_WIDTH-1:0] line_q;
   logic [STARVE_W-1:0]            starve_q;
   logic [CNT_WIDTH-1:0]           corr_q, uncorr_q;
   logic                           advance;
   logic                           capture;

   function automatic logic [POP_W-1:0] popcount(input logic [NUM_WAYS-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_WAYS; i++) n = n + POP_W'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [POP_W-1:0]     b);
      logic [CNT_WIDTH:0] sum;
      sum = {1'b0, a} + (CNT_WIDTH + 1)'(b);
      return sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
   endfunction

   // A way flagged both correctable and uncorrectable is never rewritten.
   assign fix_mask = bus.corr_err & ~bus.uncorr_err;
   assign pend_low = pend_q & (~pend_q + NUM_WAYS'(1));
   assign capture  = (state_q == CHECK) && bus.rvalid;

   // The index-advance step costs no cycle: it is taken on the exit from CHECK/WRITE.
   always_comb begin
      state_d   = state_q;
      advance   = 1'b0;
      bus.req   = 1'b0;
      bus.we    = 1'b0;
      bus.way   = '0;
      bus.wdata = '0;
      case (state_q)
         IDLE:  if (enable_i) state_d = WAIT;
         WAIT: begin
            if (!enable_i)               state_d = IDLE;
            else if (wait_cnt_q == '0)   state_d = READ;
         end
         READ: begin
            bus.req = 1'b1;
            bus.way = '1;
            if (bus.gnt) state_d = CHECK;
         end
         CHECK: begin
            if (bus.rvalid) begin
               if (fix_mask != '0) state_d = WRITE;
               else                advance = 1'b1;
            end
         end
         WRITE: begin
            bus.req = 1'b1;
            bus.we  = 1'b1;
            bus.way = pend_low;
            for (int w = 0; w < NUM_WAYS; w++)
               if (pend_low[w]) bus.wdata = line_q[w*LINE_WIDTH +: LINE_WIDTH];
            if (bus.gnt && (pend_q == pend_low)) advance = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (advance) state_d = enable_i ? WAIT : IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         index_q    <= '0;
         pend_q     <= '0;
         corr_q     <= '0;
         uncorr_q   <= '0;
         starve_q   <= '0;
         urgent_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_d == WAIT) && (state_q != WAIT))
            wait_cnt_q <= interval_i;
         else if ((state_q == WAIT) && (wait_cnt_q != '0))
            wait_cnt_q <= wait_cnt_q - INTERVAL_WIDTH'(1);
         if (advance) index_q <= index_q + INDEX_WIDTH'(1);
         if (capture) begin
            pend_q   <= fix_mask;
            corr_q   <= sat_add(corr_q, popcount(fix_mask));
            uncorr_q <= sat_add(uncorr_q, popcount(bus.uncorr_err));
         end else if ((state_q == WRITE) && bus.gnt) begin
            pend_q <= pend_q & ~pend_low;
         end
         // Starvation counter saturates at the limit so it cannot wrap during a long stall.
         if (bus.gnt) begin
            starve_q <= '0;
            urgent_o <= 1'b0;
         end else if (bus.req) begin
            if (starve_q < STARVE_W'(STARVE_LIMIT)) starve_q <= starve_q + STARVE_W'(1);
            urgent_o <= (starve_q >= STARVE_W'(STARVE_LIMIT - 1));
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (capture) line_q <= bus.rdata;
   end

   assign bus.index    = index_q;
   assign busy_o       = (state_q == READ) || (state_q == CHECK) || (state_q == WRITE);
   assign corr_cnt_o   = corr_q;
   assign uncorr_cnt_o = uncorr_q;

`ifdef SCRUB_ERR_LOG_EN
   logic                log_evt;
   logic [NUM_WAYS-1:0] uncorr_low;

   assign log_evt    = capture && (bus.uncorr_err != '0);
   assign uncorr_low = bus.uncorr_err & (~bus.uncorr_err + NUM_WAYS'(1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_valid_o <= 1'b0;
         err_index_o <= '0;
         err_way_o   <= '0;
      end else if (log_evt && (!err_valid_o || err_clear_i)) begin
         err_valid_o <= 1'b1;
         err_index_o <= index_q;
         err_way_o   <= uncorr_low;
      end else if (err_clear_i) begin
         err_valid_o <= 1'b0;
      end
   end
`endif

endmodule

// File: doc/dcache_scrub_ctrl.md
Name: dcache_scrub_ctrl

Overview:
- Background ECC scrub sequencer for the set-associative data-cache SRAM banks.
- Walks every cache index in turn and reads all ways of that index through a low-priority port of the cache-memory arbiter.
- Rewrites any way that reports a correctable error with the corrected line, and counts corrected and uncorrectable events.
- Raises an urgency flag when the functional ports starve it, so the arbiter can force one scrub access through.

Parameters:
- NUM_WAYS, 8, ways per set; one read covers all ways.
- INDEX_WIDTH, 8, index bits; the walk covers 2**INDEX_WIDTH sets.
- LINE_WIDTH, 144, encoded line width (data+ECC) written back.
- INTERVAL_WIDTH, 16, width of the idle-interval counter.
- STARVE_LIMIT, 16, consecutive un-granted request cycles before urgent_o asserts; must be >= 1.
- CNT_WIDTH, 16, width of the saturating event counters.

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, reset, asynchronous, active-low.
- enable_i, in, 1, scrubbing enabled.
- interval_i, in, INTERVAL_WIDTH, idle cycles between two index visits.
- req_o, in-arbiter request, out, 1, scrub access request.
- gnt_i, in, 1, arbiter grant (same cycle as req_o).
- we_o, out, 1, 1 = write-back, 0 = read of all ways.
- way_o, out, NUM_WAYS, one-hot way select for writes; all ones for reads.
- index_o, out, INDEX_WIDTH, set index being scrubbed.
- wdata_o, out, LINE_WIDTH, corrected line for write-back.
- rvalid_i, in, 1, read data and error flags valid (one cycle after read grant).
- rdata_i, in, NUM_WAYS*LINE_WIDTH, corrected re-encoded line per way.
- corr_err_i, in, NUM_WAYS, single-bit error corrected, per way.
- uncorr_err_i, in, NUM_WAYS, uncorrectable error, per way.
- urgent_o, out, 1, starvation flag.
- busy_o, out, 1, FSM not in IDLE/WAIT.
- corr_cnt_o, out, CNT_WIDTH, corrected-way counter.
- uncorr_cnt_o, out, CNT_WIDTH, uncorrectable-way counter.

Behaviour:
Reset values:
- All outputs 0; index 0; FSM in IDLE; counters 0.

States:
- IDLE: if enable_i, go to WAIT and load the interval counter with interval_i.
- WAIT: decrement the counter each cycle; at 0 go to READ. If interval_i=0, WAIT lasts exactly one cycle.
- READ: assert req_o, we_o=0, way_o=all ones. req_o stays high until gnt_i; index_o is stable meanwhile. On gnt_i go to CHECK.
- CHECK: wait for rvalid_i, expected the cycle after the grant.
  - On rvalid_i, capture rdata_i and pend_mask = corr_err_i & ~uncorr_err_i.
  - Add popcount(corr_err_i & ~uncorr_err_i) to corr_cnt and popcount(uncorr_err_i) to uncorr_cnt. Both counters saturate at all ones; no wrap.
  - If pend_mask != 0 go to WRITE, else go to NEXT.
- WRITE: serve the lowest set bit of pend_mask.
  - Drive req_o=1, we_o=1, way_o = that bit, wdata_o = the captured line for that way.
  - On gnt_i clear the bit; when pend_mask reaches 0 go to NEXT.
  - One granted write per cycle at most.
- NEXT: index increments by 1, wrapping from 2**INDEX_WIDTH-1 to 0. Then go to WAIT (reload interval_i) if enable_i, else IDLE.

Handshake rules:
- req_o never drops without a grant, except on disable as described below.
- Address, way and data are held while req_o=1 and not granted.

Starvation:
- A wait counter increments on each cycle with req_o & ~gnt_i and clears on any grant.
- urgent_o = 1 when counter >= STARVE_LIMIT, registered; it falls the cycle after the grant.

Disable mid-operation:
- enable_i=0 in WAIT goes to IDLE immediately.
- In READ/CHECK/WRITE the current index completes (including write-backs) before IDLE; the index advances normally.

Simultaneous errors:
- A way with both corr and uncorr set counts as uncorrectable only and is not rewritten.

Reset:
- Reset mid-operation aborts all activity; index and counters return to 0.

Optional Feature:
- SCRUB_ERR_LOG_EN
- Defined: adds outputs err_valid_o (1) and err_index_o (INDEX_WIDTH) and err_way_o (NUM_WAYS).
  - On the first uncorrectable event after reset, latch the index and the lowest erroring way and set err_valid_o.
  - Later events do not overwrite the log while err_valid_o=1.
  - Input err_clear_i (1) clears err_valid_o; if it coincides with a new event, the new event is logged.
- Not defined: these ports are absent; counters are the only error reporting.

Test Plan:
- enable_i=1, interval_i=3, gnt_i always 1, no errors -> req_o pulses every 6 cycles (WAIT 4 + READ 1 + CHECK 1 ... NEXT included); index_o 0,1,2...; index wraps 255->0; counters stay 0.
- Read of index 5 returns corr_err_i=8'b0010_0100 -> two writes: way_o=0x04 then 0x20, index_o=5, wdata_o = captured lines; corr_cnt_o=2.
- corr_err_i=uncorr_err_i=8'h01 and uncorr_err_i bit 3 set -> no write; uncorr_cnt_o +2; corr_cnt_o unchanged.
- gnt_i held 0 for 20 cycles during READ, STARVE_LIMIT=16 -> urgent_o high from cycle 17; req_o/index_o stable; urgent_o low the cycle after the grant.
- corr_cnt at 16'hFFFF, another correctable error -> stays 16'hFFFF.
- enable_i dropped during WRITE with 2 ways pending -> both writes complete, index advances, then IDLE with busy_o=0. Async reset during WAIT -> all outputs 0 immediately.
